// File: rtl/sn_gen_multi.sv
// -----------------------------------------------------------------------------
// sn_gen_multi
// Multi-channel stochastic number generator. Each of CHANNELS lanes owns a
// WIDTH-bit Fibonacci LFSR and a pre-converted threshold. A START request
// emits LEN bit-parallel beats on a valid/ready stream, then DONE pulses.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   wr_en_i       register write strobe (honoured only while idle)
//   wr_addr_i     0..CH-1 threshold, CH..2CH-1 seed, 2CH stream length
//   wr_data_i     write data (length uses the low LEN_W bits)
//   start_i       single-cycle start request
//   busy_o        high while a stream is running or draining
//   done_o        one-cycle pulse when a stream completes
//   sn_valid_o    output beat valid
//   sn_ready_i    downstream accepts the beat
//   sn_out_p_o    primary stream bit per lane
//   sn_out_n_o    negative-line bit per lane (two-line mode only)
// -----------------------------------------------------------------------------
module sn_gen_multi #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int LEN_W    = 16,
  parameter int ADDR_W   = $clog2(2*CHANNELS+1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                sn_valid_o,
  input  logic                sn_ready_i,
  output logic [CHANNELS-1:0] sn_out_p_o,
  output logic [CHANNELS-1:0] sn_out_n_o
);

  // Feedback tap masks for the supported widths.
  localparam logic [31:0] TAP_MASK32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                       (WIDTH == 16) ? 32'h0000_D008 :
                                                       32'h8020_0003;
  localparam logic [WIDTH-1:0]  TAPS     = TAP_MASK32[WIDTH-1:0];
  localparam logic [ADDR_W-1:0] LEN_ADDR = ADDR_W'(2*CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] r);
    return {r[WIDTH-2:0], ^(r & TAPS)};
  endfunction

  // Thresholds are stored already converted so the compare path is a plain
  // magnitude compare.
  function automatic logic [WIDTH-1:0] conv_thr(input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] c;
    if (MODE == 0)      c = t[WIDTH-1] ? '0 : t;
    else if (MODE == 1) c = {~t[WIDTH-1], t[WIDTH-2:0]};
    else                c = t ^ {1'b0, {(WIDTH-1){t[WIDTH-1]}}};
    return c;
  endfunction

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q;
  logic                valid_q;
  logic [CHANNELS-1:0] p_q, n_q, p_d, n_d;
  logic                done_q, done_d;

  // A write that coincides with an accepted START must not disturb the
  // stream it starts, so it is parked here and applied when the stream ends.
  logic                pw_vld_q;
  logic [ADDR_W-1:0]   pw_addr_q;
  logic [WIDTH-1:0]    pw_data_q;

  logic                step, accept, start_go, finish, defer, wr_go;
  logic                eff_en;
  logic [ADDR_W-1:0]   eff_addr;
  logic [WIDTH-1:0]    eff_data;

  assign accept   = valid_q & sn_ready_i;
  assign step     = (state_q == S_RUN) & (~valid_q | sn_ready_i);
  assign start_go = (state_q == S_IDLE) & start_i;
  assign finish   = (state_q == S_DRAIN) & accept;
  assign defer    = start_go & (len_q != '0) & wr_en_i;
  assign wr_go    = (state_q == S_IDLE) & wr_en_i & ~defer;
  assign eff_en   = wr_go | (finish & pw_vld_q);
  assign eff_addr = wr_go ? wr_addr_i : pw_addr_q;
  assign eff_data = wr_go ? wr_data_i : pw_data_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && len_q != '0) state_d = S_RUN;
      S_RUN:   if (step && cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: if (accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------- control
  always_comb begin
    cnt_d = cnt_q;
    if (start_go)  cnt_d = '0;
    else if (step) cnt_d = cnt_q + LEN_W'(1);
  end

  // A zero-length START completes immediately without entering RUN.
  assign done_d = (start_go & (len_q == '0)) | finish;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      pw_vld_q  <= 1'b0;
      pw_addr_q <= '0;
      pw_data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      if (eff_en && eff_addr == LEN_ADDR) len_q <= LEN_W'(eff_data);
      if (defer) begin
        pw_vld_q  <= 1'b1;
        pw_addr_q <= wr_addr_i;
        pw_data_q <= wr_data_i;
      end else if (finish) begin
        pw_vld_q  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- lanes
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    localparam logic [ADDR_W-1:0] THR_ADDR  = ADDR_W'(gi);
    localparam logic [ADDR_W-1:0] SEED_ADDR = ADDR_W'(CHANNELS + gi);

    logic [WIDTH-1:0] lfsr_q, thr_q, lfsr_nx;

    assign lfsr_nx = lfsr_next(lfsr_q);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lfsr_q <= WIDTH'(1);
        thr_q  <= '0;
      end else begin
        if (eff_en && eff_addr == THR_ADDR) thr_q <= conv_thr(eff_data);
        // A zero seed would lock the LFSR; substitute 1.
        if (eff_en && eff_addr == SEED_ADDR)
          lfsr_q <= (eff_data == '0) ? WIDTH'(1) : eff_data;
        else if (step)
          lfsr_q <= lfsr_nx;
      end
    end

    if (MODE == 1) begin : g_bip
      assign p_d[gi] = (lfsr_nx < thr_q);
      assign n_d[gi] = 1'b0;
    end else begin : g_mag
      // Unipolar thresholds never have the sign bit set, so masking with it
      // is harmless there and gives the two-line positive rail directly.
      logic hit;
      assign hit     = (lfsr_nx[WIDTH-1:1] < thr_q[WIDTH-2:0]);
      assign p_d[gi] = hit & ~thr_q[WIDTH-1];
      assign n_d[gi] = (MODE == 2) ? (hit & thr_q[WIDTH-1]) : 1'b0;
    end
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      p_q     <= '0;
      n_q     <= '0;
    end else if (step) begin
      valid_q <= 1'b1;
      p_q     <= p_d;
      n_q     <= n_d;
    end else if (accept) begin
      valid_q <= 1'b0;   // bits hold their last value
    end
  end

  assign done_o     = done_q;
  assign sn_valid_o = valid_q;
  assign sn_out_p_o = p_q;
  assign sn_out_n_o = n_q;

endmodule

// File: tb/tb_sn_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_sn_gen_multi
// Five generator instances (8/16/32-bit, all three modes) share one set of
// stimulus. A behavioural model predicts every accepted beat; a vector table
// checks full-period one-counts, and hand sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_sn_gen_multi;
  localparam int NI = 5;
  localparam int CH = 4;
  localparam int WS [NI] = '{8, 8, 8, 16, 32};
  localparam int MS [NI] = '{0, 1, 2, 2, 1};

  logic clk = 1'b0;
  logic rst, wr_en, start, sn_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [NI-1:0] busy_v, done_v, valid_v;
  logic [NI-1:0][CH-1:0] p_v, n_v;
  logic [39:0] obs;

  assign obs = {n_v, p_v};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sn_gen_multi #(.WIDTH(WS[gi]), .CHANNELS(CH), .MODE(MS[gi]), .LEN_W(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data[WS[gi]-1:0]), .start_i(start),
      .busy_o(busy_v[gi]), .done_o(done_v[gi]), .sn_valid_o(valid_v[gi]),
      .sn_ready_i(sn_ready), .sn_out_p_o(p_v[gi]), .sn_out_n_o(n_v[gi]));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  longint unsigned m_lfsr [NI][CH];
  longint unsigned m_thr  [NI][CH];
  int              m_len;
  int              cnt_p [NI];
  int              cnt_n [NI];
  logic [39:0]     rec [$];

  function automatic longint unsigned ref_step(int w, longint unsigned r);
    int t [4];
    longint unsigned fb;
    case (w)
      8:       t = '{7, 5, 4, 3};
      16:      t = '{15, 14, 12, 3};
      default: t = '{31, 21, 1, 0};
    endcase
    fb = 0;
    for (int k = 0; k < 4; k++) fb ^= (r >> t[k]) & 1;
    return ((r << 1) | fb) & ((64'd1 << w) - 1);
  endfunction

  // Threshold as a signed value, mapped to the stored comparator constant.
  function automatic longint unsigned ref_conv(int w, int mode, longint unsigned raw);
    longint half, u, v;
    half = longint'(1) << (w - 1);
    u = longint'(raw & ((64'd1 << w) - 1));
    v = (u >= half) ? u - 2 * half : u;
    if (mode == 0)      return (v < 0) ? 0 : v;
    else if (mode == 1) return v + half;
    else                return (v < 0) ? half + (-v - 1) : v;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < CH; c++) begin
        m_lfsr[i][c] = 1;
        m_thr[i][c]  = 0;
      end
    m_len = 0;
  endfunction

  // Only stream lengths below 256 are ever written, so every width agrees.
  function automatic void mwrite(int a, logic [31:0] d);
    for (int i = 0; i < NI; i++) begin
      longint unsigned v;
      v = longint'(d) & ((64'd1 << WS[i]) - 1);
      if (a < CH)          m_thr[i][a] = ref_conv(WS[i], MS[i], v);
      else if (a < 2 * CH) m_lfsr[i][a-CH] = (v == 0) ? 1 : v;
    end
    if (a == 2 * CH) m_len = int'(d & 32'hFF);
  endfunction

  function automatic logic [39:0] ref_beat();
    logic [39:0] b;
    b = '0;
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < CH; c++) begin
        longint unsigned r, cthr, half, mag;
        bit hit, neg;
        half = 64'd1 << (WS[i] - 1);
        r = ref_step(WS[i], m_lfsr[i][c]);
        m_lfsr[i][c] = r;
        cthr = m_thr[i][c];
        if (MS[i] == 1) begin
          b[i*CH+c] = (r < cthr);
        end else begin
          mag = cthr % half;
          neg = (cthr >= half);
          hit = ((r >> 1) < mag);
          b[i*CH+c]    = hit && !neg;
          b[20+i*CH+c] = (MS[i] == 2) && hit && neg;
        end
      end
    return b;
  endfunction

  // ------------------------------------------------------------ drivers
  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mwrite(a, d);
  endtask

  task automatic run_stream(input bit rdy_rand, input bit junk, input bit sim_wr,
                            input int sim_addr, input logic [31:0] sim_data,
                            input int abort_at);
    int len, acc, cyc;
    bit stalled, aborted;
    logic [39:0] prev, cur, exp;
    len = m_len; acc = 0; cyc = 0; stalled = 0; aborted = 0; prev = '0;
    for (int i = 0; i < NI; i++) begin cnt_p[i] = 0; cnt_n[i] = 0; end
    start = 1'b1;
    if (sim_wr) begin wr_en = 1'b1; wr_addr = 4'(sim_addr); wr_data = sim_data; end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    if (len == 0) begin
      if (sim_wr) mwrite(sim_addr, sim_data);
      chk("len0_done", done_v, 5'h1f);
      chk("len0_busy", busy_v, 5'h00);
      chk("len0_valid", valid_v, 5'h00);
      @(posedge clk); #1;
      chk("len0_done_clear", done_v, 5'h00);
      chk("len0_no_valid", valid_v, 5'h00);
      return;
    end
    while (acc < len && cyc < 4 * len + 40) begin
      cur = obs;
      wr_en = 1'b0; start = 1'b0;
      chk("busy", busy_v, 5'h1f);
      chk("done_low", done_v, 5'h00);
      chk("valid", valid_v, (cyc >= 1) ? 5'h1f : 5'h00);
      if (stalled) chk("stall_hold", cur, prev);
      sn_ready = rdy_rand ? 1'($urandom & 1) : 1'b1;
      if (valid_v == 5'h1f && sn_ready) begin
        exp = ref_beat();
        chk("beat", cur, exp);
        rec.push_back(cur);
        for (int i = 0; i < NI; i++) begin
          cnt_p[i] += int'(cur[i*CH]);
          cnt_n[i] += int'(cur[20+i*CH]);
        end
        acc++;
      end
      stalled = (valid_v == 5'h1f) && !sn_ready;
      prev = cur;
      if (junk && cyc == 3) begin
        wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 15)); wr_data = $urandom; start = 1'b1;
      end
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b1; aborted = 1;
        break;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b0;
      mreset();
      chk("rst_valid", valid_v, 5'h00);
      chk("rst_busy", busy_v, 5'h00);
      chk("rst_done", done_v, 5'h00);
      chk("rst_bits", obs, 40'h0);
      @(posedge clk); #1;
      chk("rst_no_done", done_v, 5'h00);
      return;
    end
    wr_en = 1'b0; start = 1'b0;
    chk("beats_accepted", acc, len);
    chk("end_done", done_v, 5'h1f);
    chk("end_busy", busy_v, 5'h00);
    chk("end_valid", valid_v, 5'h00);
    chk("end_bits_held", obs, prev);
    if (sim_wr) mwrite(sim_addr, sim_data);
    @(posedge clk); #1;
    chk("done_pulse_width", done_v, 5'h00);
  endtask

  typedef struct {
    logic [31:0] thr;
    bit          rdy_rand;
    int          e0p;
    int          e1p;
    int          e2p;
    int          e2n;
  } vec_t;

  initial begin
    vec_t tbl [5];
    logic [39:0] ref_q [$];
    logic [31:0] seeds [CH];

    // full-period (255 beats) one-counts on lane 0 of the 8-bit instances
    tbl[0] = '{32'h40, 1'b0, 127, 191, 127, 0};
    tbl[1] = '{32'h00, 1'b0,   0, 127,   0, 0};
    tbl[2] = '{32'h80, 1'b1,   0,   0,   0, 253};
    tbl[3] = '{32'hC0, 1'b0,   0,  63,   0, 125};
    tbl[4] = '{32'h7F, 1'b1, 253, 254, 253, 0};

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; sn_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", valid_v, 5'h00);
    chk("reset_busy", busy_v, 5'h00);
    chk("reset_done", done_v, 5'h00);
    chk("reset_bits", obs, 40'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < CH; c++) wr(c, tbl[v].thr);
      for (int c = 0; c < CH; c++) wr(CH + c, (v == 0 && c == 0) ? 32'h0 : $urandom);
      wr(2 * CH, 255);
      run_stream(tbl[v].rdy_rand, 1'b0, 1'b0, 0, 0, -1);
      chk("ones_m0_p", cnt_p[0], tbl[v].e0p);
      chk("ones_m1_p", cnt_p[1], tbl[v].e1p);
      chk("ones_m2_p", cnt_p[2], tbl[v].e2p);
      chk("ones_m2_n", cnt_n[2], tbl[v].e2n);
      $display("vector %0d thr=%0h ones m0=%0d m1=%0d m2p=%0d m2n=%0d",
               v, tbl[v].thr, cnt_p[0], cnt_p[1], cnt_p[2], cnt_n[2]);
    end

    // backpressure: random READY must reproduce the READY=1 stream exactly
    seeds = '{32'h1234_5678, 32'h0BAD_F00D, 32'h0000_0000, 32'hCAFE_0001};
    for (int c = 0; c < CH; c++) wr(c, $urandom);
    for (int c = 0; c < CH; c++) wr(CH + c, seeds[c]);
    wr(2 * CH, 100);
    rec.delete();
    run_stream(1'b0, 1'b0, 1'b0, 0, 0, -1);
    ref_q = rec;
    for (int c = 0; c < CH; c++) wr(CH + c, seeds[c]);
    rec.delete();
    run_stream(1'b1, 1'b0, 1'b0, 0, 0, -1);
    chk("bp_count", rec.size(), ref_q.size());
    for (int k = 0; k < rec.size() && k < ref_q.size(); k++) chk("bp_beat", rec[k], ref_q[k]);
    $display("backpressure stream beats=%0d", rec.size());

    // writes and START while busy, and out-of-range addresses, are ignored
    for (int a = 2 * CH + 1; a < 16; a++) wr(a, $urandom);
    wr(2 * CH, 20);
    run_stream(1'b1, 1'b1, 1'b0, 0, 0, -1);
    run_stream(1'b0, 1'b0, 1'b0, 0, 0, -1);
    $display("ignored-input streams done len=%0d", m_len);

    // write coinciding with START: the stream uses the pre-write settings
    run_stream(1'b0, 1'b0, 1'b1, 0, 32'h7F, -1);
    run_stream(1'b0, 1'b0, 1'b1, CH + 1, 32'h0, -1);
    run_stream(1'b0, 1'b0, 1'b1, 2 * CH, 6, -1);
    run_stream(1'b1, 1'b0, 1'b0, 0, 0, -1);
    $display("simultaneous-write streams done len=%0d", m_len);

    // zero length, then a normal stream right after
    wr(2 * CH, 0);
    run_stream(1'b0, 1'b0, 1'b1, 2 * CH, 3, -1);
    run_stream(1'b0, 1'b0, 1'b0, 0, 0, -1);
    $display("zero-length stream done");

    // reset mid-stream, then restart from seed 1
    wr(2 * CH, 50);
    run_stream(1'b0, 1'b0, 1'b0, 0, 0, 10);
    wr(2 * CH, 5);
    run_stream(1'b0, 1'b0, 1'b0, 0, 0, -1);
    $display("reset mid-stream and restart done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
